mul_seq_arbiter: RTL

MUL_SEQ_ARBITER -- requirements
Module: mul_seq_arbiter

---
 rtl/mul_seq_pkg.sv | 32 +++
 rtl/mul_seq_cell16.sv | 22 ++
 rtl/mul_seq_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mul_seq_pkg.sv
// Shared encodings for the sequential multiplier arbiter: FSM states,
// partial-product selects and product shift amounts (in HALF_W units).
package mul_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Encoding chosen so bit 1 picks the A half and bit 0 picks the B half.
   typedef enum logic [1:0] {
      PP_LL = 2'd0,
      PP_LH = 2'd1,
      PP_HL = 2'd2,
      PP_HH = 2'd3
   } pp_sel_e;

   localparam int unsigned SHIFT_LL  = 0;
   localparam int unsigned SHIFT_MID = 1;
   localparam int unsigned SHIFT_HH  = 2;

   function automatic int unsigned pp_shift_halves(input pp_sel_e sel);
      case (sel)
         PP_LL:   return SHIFT_LL;
         PP_HH:   return SHIFT_HH;
         default: return SHIFT_MID;
      endcase
   endfunction

endpackage

// File: rtl/mul_seq_cell16.sv
// Registered unsigned HALF_W x HALF_W multiplier cell with load enable
// and asynchronous clear.
module mul_seq_cell16 #(
   parameter int HALF_W = 16
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  en,
   input  logic [HALF_W-1:0]     a,
   input  logic [HALF_W-1:0]     b,
   output logic [2*HALF_W-1:0]   p
);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         p <= '0;
      end else if (en) begin
         p <= {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};
      end
   end

endmodule

// File: rtl/mul_seq_arbiter.sv
// Two-requester round-robin front end over one shared half-width multiplier
// cell. Define MUL_SEQ_HI_EN to support upper-word (HH product) results.
module mul_seq_arbiter
   import mul_seq_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req0_hi,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic              req1_hi,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_data
);

   localparam int HALF_W = DATA_W / 2;
`ifdef MUL_SEQ_HI_EN
   localparam int ACC_W = 2 * DATA_W;
`else
   localparam int ACC_W = DATA_W + HALF_W;
`endif

   // Handshake: a request or response moves on a rising clk edge where its
   // valid and ready are both high; ready never depends on anything but
   // IDLE, the valids and the round-robin pointer.
   state_e              state;
   pp_sel_e             sel;
   pp_sel_e             sel_d;
   pp_sel_e             last_sel;
   logic                rr_ptr;
   logic                grant;
   logic                accept;
   logic                id_q;
   logic                hi_q;
   logic                prod_vld;
   logic                cell_en;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic [HALF_W-1:0]   cell_a;
   logic [HALF_W-1:0]   cell_b;
   logic [DATA_W-1:0]   prod;
   logic [ACC_W-1:0]    prod_ext;
   logic [ACC_W-1:0]    acc;

   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = rr_ptr;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   assign req0_ready = (state == IDLE) && req0_valid && !grant;
   assign req1_ready = (state == IDLE) && req1_valid && grant;
   assign accept     = req0_ready || req1_ready;

`ifdef MUL_SEQ_HI_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q <= 1'b0;
      end else if (accept) begin
         hi_q <= grant ? req1_hi : req0_hi;
      end
   end
`else
   logic unused_hi;
   assign unused_hi = req0_hi ^ req1_hi;
   assign hi_q      = 1'b0;
`endif

   assign last_sel = hi_q ? PP_HH : PP_HL;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         sel    <= PP_LL;
         rr_ptr <= 1'b0;
         id_q   <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q    <= grant ? req1_a : req0_a;
                  b_q    <= grant ? req1_b : req0_b;
                  id_q   <= grant;
                  rr_ptr <= !grant;
                  sel    <= PP_LL;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               if (sel == last_sel) begin
                  state <= DRAIN;
               end else begin
                  sel <= pp_sel_e'(sel + 2'd1);
               end
            end
            DRAIN: state <= DONE;
            DONE: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cell_en = (state == ISSUE);
   assign cell_a  = sel[1] ? a_q[DATA_W-1:HALF_W] : a_q[HALF_W-1:0];
   assign cell_b  = sel[0] ? b_q[DATA_W-1:HALF_W] : b_q[HALF_W-1:0];

   mul_seq_cell16 #(
      .HALF_W (HALF_W)
   ) u_cell (
      .clk (clk),
      .clr (reset),
      .en  (cell_en),
      .a   (cell_a),
      .b   (cell_b),
      .p   (prod)
   );

   assign prod_ext = {{(ACC_W-DATA_W){1'b0}}, prod};

   // The cell output lags the select by one cycle; sel_d tags what it holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc      <= '0;
         prod_vld <= 1'b0;
         sel_d    <= PP_LL;
      end else begin
         prod_vld <= cell_en;
         sel_d    <= sel;
         if (accept) begin
            acc <= '0;
         end else if (prod_vld) begin
            acc <= acc + (prod_ext << (pp_shift_halves(sel_d) * HALF_W));
         end
      end
   end

   assign rsp_valid = (state == DONE);
   assign rsp_id    = id_q;
`ifdef MUL_SEQ_HI_EN
   assign rsp_data  = hi_q ? acc[2*DATA_W-1:DATA_W] : acc[DATA_W-1:0];
`else
   assign rsp_data  = acc[DATA_W-1:0];
`endif

endmodule
